// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer for the single-cycle CPU core: gates commit enable,
// holds the core in reset while idle, and halts on breakpoint/BREAK/limits.
module cpu_run_ctrl #(
  parameter logic [31:0] BREAK_INST = 32'h0000000D,
  parameter int unsigned MAX_CYCLES = 2048
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic        cpu_en,
  output logic        cpu_rst,
  output logic [2:0]  state,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [31:0] cycle_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 3;

  localparam logic [2:0] OP_START     = 3'd1;
  localparam logic [2:0] OP_HALT      = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_RUN_N     = 3'd4;
  localparam logic [2:0] OP_SET_BP    = 3'd5;
  localparam logic [2:0] OP_CLR_BP    = 3'd6;
  localparam logic [2:0] OP_RESET_CPU = 3'd7;

  localparam logic [CW-1:0] CAUSE_NONE  = 3'd0;
  localparam logic [CW-1:0] CAUSE_CMD   = 3'd1;
  localparam logic [CW-1:0] CAUSE_BP    = 3'd2;
  localparam logic [CW-1:0] CAUSE_COUNT = 3'd3;
  localparam logic [CW-1:0] CAUSE_BREAK = 3'd4;
  localparam logic [CW-1:0] CAUSE_MAX   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_COUNT = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  state_e            state_q, state_d, cmd_base_c;
  logic [CW-1:0]     cause_q, cause_d, stop_cause_c;
  logic [XLEN-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   run_n_q, run_n_d;
  logic [XLEN-1:0]   bp_addr_q, bp_addr_d;
  logic              bp_en_q, bp_en_d;
  logic              skip_q, skip_d;
  logic              active_c, stop_c, stop_bp_c, stop_brk_c, stop_max_c;
  logic              cmd_acc_c, halt_cmd_c, leave_c;

  // Stop conditions and the combinational commit enable
  always_comb begin
    stop_bp_c    = bp_en_q && (pc_in == bp_addr_q) && !skip_q;
    stop_brk_c   = (inst_in == BREAK_INST);
    stop_max_c   = (MAX_CYCLES != 0) && (cnt_q >= XLEN'(MAX_CYCLES));
    stop_c       = stop_bp_c || stop_brk_c || stop_max_c;
    stop_cause_c = stop_max_c ? CAUSE_MAX : (stop_brk_c ? CAUSE_BREAK : CAUSE_BP);
    active_c     = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_COUNT);
    cmd_acc_c    = cmd_valid && cmd_ready;
    halt_cmd_c   = cmd_acc_c && (cmd_op == OP_HALT);
    cpu_en       = active_c && !stop_c && !halt_cmd_c;
  end

  // Next-state: autonomous transitions first, then command dispatch
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    run_n_d    = run_n_q;
    bp_addr_d  = bp_addr_q;
    bp_en_d    = bp_en_q;
    skip_d     = skip_q;
    leave_c    = 1'b0;
    cmd_base_c = state_q;

    if (cpu_en) begin
      skip_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + XLEN'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (stop_c) begin
          state_d = ST_HALT;
          cause_d = stop_cause_c;
        end else if (halt_cmd_c) begin
          state_d = ST_HALT;
          cause_d = CAUSE_CMD;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
        cause_d = stop_c ? stop_cause_c : CAUSE_CMD;
      end
      ST_COUNT: begin
        if (stop_c) begin
          state_d = ST_HALT;
          cause_d = stop_cause_c;
        end else if (halt_cmd_c) begin
          state_d = ST_HALT;
          cause_d = CAUSE_CMD;
        end else begin
          run_n_d = run_n_q - XLEN'(1);
          if (run_n_q == XLEN'(1)) begin
            state_d = ST_HALT;
            cause_d = CAUSE_COUNT;
          end
        end
      end
      default: ;
    endcase

    // A stop in the same cycle lands in HALT before the command is applied
    if (stop_c && ((state_q == ST_RUN) || (state_q == ST_COUNT))) cmd_base_c = ST_HALT;

    if (cmd_acc_c) begin
      if ((cmd_base_c == ST_IDLE) || (cmd_base_c == ST_HALT)) begin
        case (cmd_op)
          OP_START: begin
            state_d = ST_RUN;
            leave_c = 1'b1;
          end
          OP_STEP: begin
            state_d = ST_STEP;
            leave_c = 1'b1;
          end
          OP_RUN_N: begin
            if (cmd_arg != '0) begin
              state_d = ST_COUNT;
              run_n_d = cmd_arg;
              leave_c = 1'b1;
            end
          end
          default: ;
        endcase
        if (leave_c && (cmd_base_c == ST_HALT)) begin
          skip_d  = 1'b1;
          cause_d = CAUSE_NONE;
        end
      end
      case (cmd_op)
        OP_SET_BP: begin
          bp_addr_d = cmd_arg;
          bp_en_d   = 1'b1;
        end
        OP_CLR_BP: bp_en_d = 1'b0;
        OP_RESET_CPU: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cause_d = CAUSE_NONE;
          skip_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      cnt_q     <= '0;
      run_n_q   <= '0;
      bp_addr_q <= '0;
      bp_en_q   <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      run_n_q   <= run_n_d;
      bp_addr_q <= bp_addr_d;
      bp_en_q   <= bp_en_d;
      skip_q    <= skip_d;
    end
  end

  assign cmd_ready  = (state_q != ST_STEP);
  assign cpu_rst    = (state_q == ST_IDLE);
  assign halted     = (state_q == ST_HALT);
  assign state      = state_q;
  assign halt_cause = cause_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a tiny core model advances pc on commits,
// expectations are queued with each stimulus step and drained after the DUT responds.
module tb_cpu_run_ctrl;

  localparam logic [31:0] PC_BASE = 32'h00400000;
  localparam logic [31:0] BP_ADDR = 32'h00400010;
  localparam logic [31:0] BRK     = 32'h0000000D;

  localparam logic [2:0] OP_START = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3, OP_RUN_N = 3'd4;
  localparam logic [2:0] OP_SET_BP = 3'd5, OP_CLR_BP = 3'd6, OP_RESET_CPU = 3'd7;

  localparam int S_STATE = 0, S_RST = 1, S_EN = 2, S_HALTED = 3;
  localparam int S_CAUSE = 4, S_CNT = 5, S_READY = 6, S_COMMITS = 7;

  logic        clk_in, reset, cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg, pc_in, inst_in;
  logic        cpu_en, cpu_rst, halted;
  logic [2:0]  state, halt_cause;
  logic [31:0] cycle_cnt;

  int checks, errors, commits, base;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  cpu_run_ctrl dut (
    .clk_in(clk_in), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_in(pc_in), .inst_in(inst_in),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst), .state(state), .halted(halted),
    .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_STATE:   return {29'd0, state};
      S_RST:     return {31'd0, cpu_rst};
      S_EN:      return {31'd0, cpu_en};
      S_HALTED:  return {31'd0, halted};
      S_CAUSE:   return {29'd0, halt_cause};
      S_CNT:     return cycle_cnt;
      S_READY:   return {31'd0, cmd_ready};
      default:   return 32'(commits);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock; the core model commits (pc += 4) when cpu_en was high at the edge
  task automatic tick();
    logic en;
    @(negedge clk_in);
    en = cpu_en;
    @(posedge clk_in);
    #1;
    if (en === 1'b1) commits++;
    if (cpu_rst === 1'b1) pc_in = PC_BASE;
    else if (en === 1'b1) pc_in = pc_in + 32'd4;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_arg   = 32'd0;
    #1;
    drain();
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && halted !== 1'b1; i++) tick();
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0;
    pc_in = PC_BASE; inst_in = 32'd0;
    checks = 0; errors = 0; commits = 0; base = 0;

    tick(); tick();
    expect_val("rst_state", S_STATE, 32'd0);
    expect_val("rst_cpu_rst", S_RST, 32'd1);
    expect_val("rst_cpu_en", S_EN, 32'd0);
    expect_val("rst_halted", S_HALTED, 32'd0);
    expect_val("rst_cause", S_CAUSE, 32'd0);
    expect_val("rst_cnt", S_CNT, 32'd0);
    expect_val("rst_ready", S_READY, 32'd1);
    drain();
    reset = 1'b1;

    // Free run from IDLE
    expect_val("start_state", S_STATE, 32'd1);
    expect_val("start_cpu_rst", S_RST, 32'd0);
    expect_val("start_cpu_en", S_EN, 32'd1);
    expect_val("start_cnt", S_CNT, 32'd0);
    send(OP_START, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      expect_val("run_cnt", S_CNT, 32'(i));
      tick(); #1; drain();
    end

    // Breakpoint armed mid-run hits at the next pc; then RESET_CPU keeps it armed
    expect_val("setbp_cnt", S_CNT, 32'd4);
    expect_val("setbp_en_blocked", S_EN, 32'd0);
    expect_val("setbp_state", S_STATE, 32'd1);
    send(OP_SET_BP, BP_ADDR);
    expect_val("rcpu_state", S_STATE, 32'd0);
    expect_val("rcpu_cpu_rst", S_RST, 32'd1);
    expect_val("rcpu_cnt", S_CNT, 32'd0);
    expect_val("rcpu_cause", S_CAUSE, 32'd0);
    send(OP_RESET_CPU, 32'd0);

    base = commits;
    expect_val("bp_start_state", S_STATE, 32'd1);
    send(OP_START, 32'd0);
    wait_halt(20);
    expect_val("bp_halted", S_HALTED, 32'd1);
    expect_val("bp_cause", S_CAUSE, 32'd2);
    expect_val("bp_cnt", S_CNT, 32'd4);
    expect_val("bp_commits", S_COMMITS, 32'(base + 4));
    expect_val("bp_state", S_STATE, 32'd4);
    drain();

    // Restart at the breakpoint pc: skip lets it commit
    expect_val("skip_state", S_STATE, 32'd1);
    expect_val("skip_cause_clr", S_CAUSE, 32'd0);
    expect_val("skip_en", S_EN, 32'd1);
    send(OP_START, 32'd0);
    expect_val("skip_cnt", S_CNT, 32'd5);
    expect_val("skip_run", S_STATE, 32'd1);
    tick(); #1; drain();

    // HALT command forces cpu_en low in its own cycle
    cmd_valid = 1'b1; cmd_op = OP_HALT; #1;
    expect_val("halt_cmd_en", S_EN, 32'd0);
    drain();
    base = commits;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0; #1;
    expect_val("halt_cmd_state", S_STATE, 32'd4);
    expect_val("halt_cmd_cause", S_CAUSE, 32'd1);
    expect_val("halt_cmd_cnt", S_CNT, 32'd5);
    expect_val("halt_cmd_commits", S_COMMITS, 32'(base));
    drain();

    expect_val("clrbp_state", S_STATE, 32'd4);
    send(OP_CLR_BP, 32'd0);
    expect_val("rcpu2_cnt", S_CNT, 32'd0);
    send(OP_RESET_CPU, 32'd0);

    // RUN_N 3 from IDLE, then RUN_N 0 is a no-op
    base = commits;
    expect_val("runn_state", S_STATE, 32'd3);
    send(OP_RUN_N, 32'd3);
    wait_halt(20);
    expect_val("runn_halted", S_HALTED, 32'd1);
    expect_val("runn_cause", S_CAUSE, 32'd3);
    expect_val("runn_cnt", S_CNT, 32'd3);
    expect_val("runn_commits", S_COMMITS, 32'(base + 3));
    drain();
    expect_val("runn0_state", S_STATE, 32'd4);
    expect_val("runn0_cause", S_CAUSE, 32'd3);
    expect_val("runn0_cnt", S_CNT, 32'd3);
    send(OP_RUN_N, 32'd0);

    // Two single steps
    for (int k = 0; k < 2; k++) begin
      base = commits;
      expect_val("step_state", S_STATE, 32'd2);
      expect_val("step_ready", S_READY, 32'd0);
      expect_val("step_en", S_EN, 32'd1);
      send(OP_STEP, 32'd0);
      expect_val("step_done_state", S_STATE, 32'd4);
      expect_val("step_done_cause", S_CAUSE, 32'd1);
      expect_val("step_done_cnt", S_CNT, 32'(4 + k));
      expect_val("step_done_commits", S_COMMITS, 32'(base + 1));
      tick(); #1; drain();
    end

    // BREAK instruction blocks the step
    inst_in = BRK;
    base = commits;
    expect_val("brk_state", S_STATE, 32'd2);
    expect_val("brk_en", S_EN, 32'd0);
    send(OP_STEP, 32'd0);
    expect_val("brk_cause", S_CAUSE, 32'd4);
    expect_val("brk_halted", S_HALTED, 32'd1);
    expect_val("brk_cnt", S_CNT, 32'd5);
    expect_val("brk_commits", S_COMMITS, 32'(base));
    tick(); #1; drain();
    inst_in = 32'd0;

    // Global instruction limit
    expect_val("rcpu3_cnt", S_CNT, 32'd0);
    send(OP_RESET_CPU, 32'd0);
    base = commits;
    send(OP_START, 32'd0);
    wait_halt(2100);
    expect_val("max_halted", S_HALTED, 32'd1);
    expect_val("max_cause", S_CAUSE, 32'd5);
    expect_val("max_cnt", S_CNT, 32'd2048);
    expect_val("max_commits", S_COMMITS, 32'(base + 2048));
    drain();
    expect_val("max_restart_state", S_STATE, 32'd1);
    expect_val("max_restart_en", S_EN, 32'd0);
    expect_val("max_restart_cause", S_CAUSE, 32'd0);
    send(OP_START, 32'd0);
    // Stop and a STEP command coincide: halt first, then STEP from HALT
    expect_val("coinc_state", S_STATE, 32'd2);
    expect_val("coinc_cause", S_CAUSE, 32'd0);
    expect_val("coinc_en", S_EN, 32'd0);
    expect_val("coinc_cnt", S_CNT, 32'd2048);
    send(OP_STEP, 32'd0);
    expect_val("coinc_rehalt_state", S_STATE, 32'd4);
    expect_val("coinc_rehalt_cause", S_CAUSE, 32'd5);
    expect_val("coinc_rehalt_cnt", S_CNT, 32'd2048);
    tick(); #1; drain();

    // Pin reset in the middle of COUNT
    send(OP_RESET_CPU, 32'd0);
    expect_val("cnt10_state", S_STATE, 32'd3);
    send(OP_RUN_N, 32'd10);
    tick(); tick();
    expect_val("midcnt_cnt", S_CNT, 32'd2);
    #1; drain();
    reset = 1'b0;
    tick(); #1;
    expect_val("hwrst_state", S_STATE, 32'd0);
    expect_val("hwrst_cpu_rst", S_RST, 32'd1);
    expect_val("hwrst_en", S_EN, 32'd0);
    expect_val("hwrst_halted", S_HALTED, 32'd0);
    expect_val("hwrst_cause", S_CAUSE, 32'd0);
    expect_val("hwrst_cnt", S_CNT, 32'd0);
    drain();
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
